// File: rtl/expr_pipe_pkg.sv
// Shared opcode enum and per-lane result record for expr_pipe_eval.
package expr_pipe_pkg;

  typedef enum logic [2:0] {
    OP_ADDM = 3'd0,
    OP_SUBS = 3'd1,
    OP_MULU = 3'd2,
    OP_ASHR = 3'd3,
    OP_CMP  = 3'd4,
    OP_CEQ  = 3'd5,
    OP_TERN = 3'd6,
    OP_ACC  = 3'd7
  } op_e;

  // Widest lane the result record can carry; lanes zero-extend into it.
  localparam int unsigned MaxW = 32;

  typedef struct packed {
    logic [MaxW-1:0] y;
    logic            ovf;
  } lane_res_t;

endpackage

// File: rtl/expr_pipe_eval_lane.sv
// Combinational per-lane evaluator: opcodes 0-6 plus the accumulator sum.
// EXPR_PIPE_SATURATE_EN clamps ADDM/SUBS on overflow instead of wrapping.
module expr_lane
  import expr_pipe_pkg::*;
#(
  parameter int unsigned W    = 6,
  parameter int unsigned ACCW = 10
) (
  input  op_e             op,
  input  logic [W-1:0]    a_u,
  input  logic [W-1:0]    a_s,
  input  logic [W-1:0]    b_u,
  input  logic [W-1:0]    b_s,
  input  logic [ACCW-1:0] acc_base,
  output lane_res_t       res,
  output logic [ACCW-1:0] acc_sum
);

  localparam int unsigned ShW = $clog2(W);

  logic [W:0]      add_sum;
  logic [W-1:0]    sub_d;
  logic            sub_ovf;
  logic [2*W-1:0]  mul_p;
  logic [ACCW-1:0] a_ext;
  logic            acc_ovf;
  logic [W-1:0]    y;
  logic            ovf;

  // Mixed signed/unsigned add is unsigned: carry out is the overflow.
  assign add_sum = {1'b0, a_s} + {1'b0, b_u};
  assign sub_d   = a_s - b_s;
  assign sub_ovf = (a_s[W-1] != b_s[W-1]) && (sub_d[W-1] != a_s[W-1]);
  assign mul_p   = {{W{1'b0}}, a_u} * {{W{1'b0}}, b_u};
  assign a_ext   = ACCW'($signed(a_s));
  assign acc_sum = acc_base + a_ext;
  assign acc_ovf = (acc_base[ACCW-1] == a_ext[ACCW-1]) && (acc_sum[ACCW-1] != acc_base[ACCW-1]);

  always_comb begin
    y   = '0;
    ovf = 1'b0;
    unique case (op)
      OP_ADDM: begin
        y   = add_sum[W-1:0];
        ovf = add_sum[W];
`ifdef EXPR_PIPE_SATURATE_EN
        if (add_sum[W]) y = '1;
`endif
      end
      OP_SUBS: begin
        y   = sub_d;
        ovf = sub_ovf;
`ifdef EXPR_PIPE_SATURATE_EN
        if (sub_ovf) y = a_s[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
      end
      OP_MULU: begin
        y   = mul_p[W-1:0];
        ovf = |mul_p[2*W-1:W];
      end
      OP_ASHR: y = $signed(a_s) >>> b_u[ShW-1:0];
      OP_CMP: begin
        y[1] = $signed(a_s) < $signed(b_s);
        y[0] = a_u < b_u;
      end
      OP_CEQ: begin
        y[1] = a_u === b_u;
        y[0] = a_s == b_u;
      end
      OP_TERN: y = (|a_u) ? b_s : b_u;
      OP_ACC: begin
        y   = acc_sum[W-1:0];
        ovf = acc_ovf;
      end
      default: ;
    endcase
  end

  assign res = '{y: MaxW'(y), ovf: ovf};

endmodule

// File: rtl/expr_pipe_eval.sv
// Two-stage valid/ready expression pipeline over LANES lanes with per-lane accumulators.
// Optional EXPR_PIPE_SATURATE_EN (in expr_lane) saturates ADDM/SUBS.
module expr_pipe_eval
  import expr_pipe_pkg::*;
#(
  parameter int unsigned W     = 6,
  parameter int unsigned LANES = 3,
  parameter int unsigned ACCW  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [LANES*W-1:0] a_u,
  input  logic [LANES*W-1:0] a_s,
  input  logic [LANES*W-1:0] b_u,
  input  logic [LANES*W-1:0] b_s,
  input  logic               acc_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] y,
  output logic [LANES-1:0]   ovf
);

  logic               s1_valid;
  op_e                s1_op;
  logic [LANES*W-1:0] s1_a_u, s1_a_s, s1_b_u, s1_b_s;
  logic [ACCW-1:0]    acc_q    [LANES];
  logic [ACCW-1:0]    acc_base [LANES];
  logic [ACCW-1:0]    acc_sum  [LANES];
  lane_res_t          res      [LANES];
  logic               s2_load;
  logic               acc_fire;

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;
  assign acc_fire = s1_valid && s2_load && (s1_op == OP_ACC);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    // A clear coincident with an ACC beat restarts the sum from zero.
    assign acc_base[i] = acc_clr ? '0 : acc_q[i];

    expr_lane #(
      .W    (W),
      .ACCW (ACCW)
    ) u_lane (
      .op       (s1_op),
      .a_u      (s1_a_u[i*W +: W]),
      .a_s      (s1_a_s[i*W +: W]),
      .b_u      (s1_b_u[i*W +: W]),
      .b_s      (s1_b_s[i*W +: W]),
      .acc_base (acc_base[i]),
      .res      (res[i]),
      .acc_sum  (acc_sum[i])
    );

    if (W < MaxW) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^res[i].y[MaxW-1:W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_ADDM;
      s1_a_u   <= '0;
      s1_a_s   <= '0;
      s1_b_u   <= '0;
      s1_b_s   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op  <= op_e'(op);
        s1_a_u <= a_u;
        s1_a_s <= a_s;
        s1_b_u <= b_u;
        s1_b_s <= b_s;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      ovf       <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        for (int i = 0; i < LANES; i++) begin
          y[i*W +: W] <= res[i].y[W-1:0];
          ovf[i]      <= res[i].ovf;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
    end else if (acc_fire) begin
      for (int i = 0; i < LANES; i++) acc_q[i] <= acc_sum[i];
    end else if (acc_clr) begin
      for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
    end
  end

endmodule
